// File: rtl/gpr_wb_ctrl.sv
// Write-back controller: round-robin arbitration of ALU/load results onto the
// register file write port, plus a pending-write scoreboard for RAW hazard detection.
module gpr_wb_ctrl #(
    parameter int unsigned D_WIDTH  = 8,
    parameter int unsigned A_WIDTH  = 3,
    parameter int unsigned REG_DEEP = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_req,
    input  logic [A_WIDTH-1:0]  alu_rd,
    input  logic [D_WIDTH-1:0]  alu_data,
    output logic                alu_ack,
    input  logic                mem_req,
    input  logic [A_WIDTH-1:0]  mem_rd,
    input  logic [D_WIDTH-1:0]  mem_data,
    output logic                mem_ack,
    input  logic                issue_valid,
    input  logic [A_WIDTH-1:0]  issue_rd,
    input  logic [A_WIDTH-1:0]  chk_r1,
    input  logic [A_WIDTH-1:0]  chk_r2,
    output logic                hz_r1,
    output logic                hz_r2,
    output logic                wb_we,
    output logic [A_WIDTH-1:0]  wb_rd,
    output logic [D_WIDTH-1:0]  wb_data,
    output logic [REG_DEEP-1:0] pending
);

    logic                last;
    logic                grant;
    logic [A_WIDTH-1:0]  grant_rd;
    logic [D_WIDTH-1:0]  grant_data;
    logic [REG_DEEP-1:0] pend_q;
    logic [REG_DEEP-1:0] pend_nxt;

    // Arbitration and scoreboard next-state; `last` = 1 means MEM was granted most recently.
    always_comb begin
        alu_ack    = 1'b0;
        mem_ack    = 1'b0;
        grant_rd   = alu_rd;
        grant_data = alu_data;
        pend_nxt   = pend_q;
        if (reset) begin
            alu_ack = alu_req && (!mem_req || last);
            mem_ack = mem_req && (!alu_req || !last);
        end
        if (mem_ack) begin
            grant_rd   = mem_rd;
            grant_data = mem_data;
        end
        // Clear first so that a same-edge re-issue of the register wins.
        if (wb_we) begin
            pend_nxt[wb_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != A_WIDTH'(0))) begin
            pend_nxt[issue_rd] = 1'b1;
        end
    end

    assign grant   = alu_ack || mem_ack;
    assign hz_r1   = pend_q[chk_r1];
    assign hz_r2   = pend_q[chk_r2];
    assign pending = pend_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last    <= 1'b1;
            wb_we   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
            pend_q  <= '0;
        end else begin
            pend_q <= pend_nxt;
            if (grant) begin
                last    <= mem_ack;
                wb_we   <= (grant_rd != A_WIDTH'(0));
                wb_rd   <= grant_rd;
                wb_data <= grant_data;
            end else begin
                wb_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Bench for gpr_wb_ctrl: directed scenarios followed by random traffic, all
// checked against a behavioural model of arbitration, write port and scoreboard.
module tb_gpr_wb_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_req, mem_req, issue_valid;
    logic [2:0] alu_rd, mem_rd, issue_rd, chk_r1, chk_r2;
    logic [7:0] alu_data, mem_data;
    logic       alu_ack, mem_ack, hz_r1, hz_r2, wb_we;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic [7:0] pending;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit         m_pend [8];
    int         m_owner;          // 0 = ALU, 1 = MEM granted most recently
    bit         m_we;
    logic [2:0] m_rd;
    logic [7:0] m_data;
    bit         m_ga, m_gm;
    logic       s_alu_ack, s_mem_ack;
    int         alu_wait, mem_wait;

    gpr_wb_ctrl #(.D_WIDTH(8), .A_WIDTH(3), .REG_DEEP(8)) dut (
        .clk(clk), .reset(reset),
        .alu_req(alu_req), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ack(alu_ack),
        .mem_req(mem_req), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ack(mem_ack),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .chk_r1(chk_r1), .chk_r2(chk_r2), .hz_r1(hz_r1), .hz_r2(hz_r2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_owner = 1;
        m_we    = 1'b0;
        m_rd    = 3'd0;
        m_data  = 8'd0;
        m_ga    = 1'b0;
        m_gm    = 1'b0;
    endtask

    function automatic logic [7:0] pend_vec();
        logic [7:0] v = 8'd0;
        for (int i = 1; i < 8; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // One clock: check at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (alu_req && mem_req) begin
            m_ga = (m_owner == 1);
            m_gm = (m_owner == 0);
        end else begin
            m_ga = alu_req;
            m_gm = mem_req;
        end
        s_alu_ack = alu_ack;
        s_mem_ack = mem_ack;
        chk("alu_ack", 32'(alu_ack), 32'(m_ga));
        chk("mem_ack", 32'(mem_ack), 32'(m_gm));
        chk("hz_r1", 32'(hz_r1), 32'(m_pend[chk_r1]));
        chk("hz_r2", 32'(hz_r2), 32'(m_pend[chk_r2]));
        chk("wb_we", 32'(wb_we), 32'(m_we));
        chk("wb_rd", 32'(wb_rd), 32'(m_rd));
        chk("wb_data", 32'(wb_data), 32'(m_data));
        chk("pending", 32'(pending), 32'(pend_vec()));
        alu_wait = (alu_req && !m_ga) ? alu_wait + 1 : 0;
        mem_wait = (mem_req && !m_gm) ? mem_wait + 1 : 0;
        @(posedge clk);
        if (m_we) m_pend[m_rd] = 1'b0;
        if (issue_valid && issue_rd != 3'd0) m_pend[issue_rd] = 1'b1;
        if (m_ga) begin
            m_we = (alu_rd != 3'd0); m_rd = alu_rd; m_data = alu_data; m_owner = 0;
        end else if (m_gm) begin
            m_we = (mem_rd != 3'd0); m_rd = mem_rd; m_data = mem_data; m_owner = 1;
        end else begin
            m_we = 1'b0;
        end
        #1;
    endtask

    initial begin
        reset = 1'b0;
        alu_req = 1'b0; mem_req = 1'b0; issue_valid = 1'b0;
        alu_rd = 3'd0; mem_rd = 3'd0; issue_rd = 3'd0; chk_r1 = 3'd0; chk_r2 = 3'd0;
        alu_data = 8'd0; mem_data = 8'd0;
        alu_wait = 0; mem_wait = 0;
        model_reset();
        #12;
        chk("por_wb_we", 32'(wb_we), 32'd0);
        chk("por_pending", 32'(pending), 32'd0);
        chk("por_wb_rd", 32'(wb_rd), 32'd0);
        chk("por_wb_data", 32'(wb_data), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Single ALU write to r3
        issue_valid = 1'b1; issue_rd = 3'd3; chk_r1 = 3'd3; chk_r2 = 3'd0;
        cycle();
        issue_valid = 1'b0;
        alu_req = 1'b1; alu_rd = 3'd3; alu_data = 8'hA5;
        cycle();
        chk("t1_ack", 32'(s_alu_ack), 32'd1);
        alu_req = 1'b0;
        chk("t1_we", 32'(wb_we), 32'd1);
        chk("t1_rd", 32'(wb_rd), 32'd3);
        chk("t1_data", 32'(wb_data), 32'hA5);
        cycle();
        chk("t1_pend_clr", 32'(pending[3]), 32'd0);
        cycle();
        chk("t1_hz_clr", 32'(hz_r1), 32'd0);

        // rd = 0 discard
        mem_req = 1'b1; mem_rd = 3'd0; mem_data = 8'hFF; chk_r1 = 3'd0;
        cycle();
        chk("rd0_ack", 32'(s_mem_ack), 32'd1);
        mem_req = 1'b0;
        chk("rd0_we", 32'(wb_we), 32'd0);
        chk("rd0_pending", 32'(pending), 32'd0);
        cycle();
        chk("rd0_hz", 32'(hz_r1), 32'd0);

        // Set/clear collision on r5
        issue_valid = 1'b1; issue_rd = 3'd5; chk_r2 = 3'd5;
        cycle();
        issue_valid = 1'b0;
        alu_req = 1'b1; alu_rd = 3'd5; alu_data = 8'h3C;
        cycle();
        alu_req = 1'b0;
        issue_valid = 1'b1; issue_rd = 3'd5;
        chk("coll_we", 32'(wb_we), 32'd1);
        chk("coll_rd", 32'(wb_rd), 32'd5);
        cycle();
        issue_valid = 1'b0;
        chk("coll_pend5", 32'(pending[5]), 32'd1);
        cycle();
        chk("coll_hz_hold", 32'(hz_r2), 32'd1);

        // Mid-stream reset with a write in flight
        issue_valid = 1'b1; issue_rd = 3'd4;
        alu_req = 1'b1; alu_rd = 3'd4; alu_data = 8'h77;
        mem_req = 1'b1; mem_rd = 3'd6; mem_data = 8'h66;
        cycle();
        issue_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_alu_ack", 32'(alu_ack), 32'd0);
        chk("rst_mem_ack", 32'(mem_ack), 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_we", 32'(wb_we), 32'd0);
        chk("rst_hold_ack", 32'({alu_ack, mem_ack}), 32'd0);
        model_reset();
        reset = 1'b1;

        // Continuous contention: ALU first, then strict alternation
        alu_rd = 3'd1; mem_rd = 3'd2;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (i == 0) chk("cont_first_alu", 32'(s_alu_ack), 32'd1);
            chk("cont_alt", 32'({s_alu_ack, s_mem_ack}), (i % 2 == 0) ? 32'd2 : 32'd1);
            chk("cont_wait", 32'(alu_wait <= 1 && mem_wait <= 1), 32'd1);
            if (i > 0) chk("cont_we", 32'(wb_we), 32'd1);
            if (m_ga) alu_data = 8'($urandom);
            if (m_gm) mem_data = 8'($urandom);
        end
        alu_req = 1'b0; mem_req = 1'b0;
        cycle();

        // Random traffic with hold-until-ack requesters
        for (int i = 0; i < 400; i++) begin
            if (!alu_req && $urandom_range(0, 1) == 1) begin
                alu_req = 1'b1; alu_rd = 3'($urandom); alu_data = 8'($urandom);
            end
            if (!mem_req && $urandom_range(0, 1) == 1) begin
                mem_req = 1'b1; mem_rd = 3'($urandom); mem_data = 8'($urandom);
            end
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd = 3'($urandom);
            chk_r1 = 3'($urandom);
            chk_r2 = 3'($urandom);
            cycle();
            chk("rand_wait", 32'(alu_wait <= 1 && mem_wait <= 1), 32'd1);
            if (m_ga) alu_req = 1'b0;
            if (m_gm) mem_req = 1'b0;
        end
        alu_req = 1'b0; mem_req = 1'b0; issue_valid = 1'b0;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gpr_wb_ctrl.md
# gpr_wb_ctrl

Write-back controller for the 8-entry general-purpose register file. It shares the register file's single write port between two producers, the ALU and the memory/load unit, using round-robin arbitration with a req/ack handshake. It also keeps a pending-write scoreboard so the decode stage can detect read-after-write hazards on source registers r1/r2. It sits between the execute/memory stages and the register file's write-port inputs (write enable, destination address, write data).

## Interface
- D_WIDTH, 8, data width of register and write-back bus
- A_WIDTH, 3, register address width
- REG_DEEP, 8, number of registers; must equal 2**A_WIDTH
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- alu_req  in  1  ALU has a result to write back
- alu_rd  in  A_WIDTH  ALU destination register
- alu_data  in  D_WIDTH  ALU result
- alu_ack  out  1  ALU result accepted this cycle
- mem_req  in  1  load unit has a result to write back
- mem_rd  in  A_WIDTH  load destination register
- mem_data  in  D_WIDTH  load data
- mem_ack  out  1  load result accepted this cycle
- issue_valid  in  1  decode issues an instruction that will write issue_rd
- issue_rd  in  A_WIDTH  destination of the issued instruction
- chk_r1  in  A_WIDTH  source register 1 being decoded
- chk_r2  in  A_WIDTH  source register 2 being decoded
- hz_r1  out  1  chk_r1 has a write pending
- hz_r2  out  1  chk_r2 has a write pending
- wb_we  out  1  register file write enable
- wb_rd  out  A_WIDTH  register file write address
- wb_data  out  D_WIDTH  register file write data
- pending  out  REG_DEEP  scoreboard vector; bit i set means register i has an outstanding write

## Operation
- **Handshake.**
  - A requester raises req with rd/data stable and holds all three until it sees ack high at a clock edge.
  - ack is combinational from req and the round-robin pointer. It is a single-cycle pulse per transfer.
  - A requester may present a new request in the cycle after its ack.
- **Arbitration.**
  - Only one requester is active: that requester is acked.
  - Both requesters active: the requester not favoured by `last` is acked. `last` is a 1-bit register recording the most recent grant (0 = ALU, 1 = MEM).
  - `last` updates only on a grant.
  - Reset value of `last` is 1, so the ALU wins the first contention.
- **Write port.**
  - On the edge where an ack is high, wb_rd and wb_data register the granted rd/data.
  - On that same edge, wb_we registers 1 if the granted rd != 0, else 0.
  - With no grant, wb_we registers 0. wb_rd and wb_data hold their previous values.
  - Register 0 is never written. A request with rd = 0 is still acked and then discarded.
- **Scoreboard.**
  - Set: at an edge with issue_valid = 1 and issue_rd != 0, bit pending[issue_rd] sets.
  - Clear: at an edge with wb_we = 1, bit pending[wb_rd] clears. This is the same edge at which the register file captures the data.
  - Same-register set and clear on one edge: set wins, because a newer producer has been issued.
  - A set of an already-pending bit leaves it set; there is no counting.
- **Hazard outputs.** hz_r1 = pending[chk_r1] and hz_r2 = pending[chk_r2], both combinational. Because pending[0] is always 0, a source of r0 never reports a hazard.
- **Reset.**
  - All outputs go to 0 while reset is low: wb_we = 0, wb_rd = 0, wb_data = 0, pending = 0, acks = 0.
  - Asserting reset mid-operation discards any registered, not-yet-committed write and clears all pending bits.
  - No ack is issued while reset is low.

## Timing
- Result-to-write latency is 1 cycle. ack in cycle N gives wb_we = 1 in cycle N+1, and the register file commits at the end of N+1.
- pending clears at the end of N+1, so hz_* stays 1 through N+1. A dependent read in N+2 sees the new value.
- Throughput is one write-back per cycle. Under continuous contention the grants alternate ALU, MEM, ALU, and so on.
- A request waits at most 1 cycle when the other requester is also active.
- Issue-to-pending latency is 1 cycle: issue in cycle N makes hz_* visible from cycle N+1.

## Test plan
- **Reset values.** Assert reset low mid-stream with a grant in flight, then release. Required: wb_we = 0, pending = 8'h00, both acks 0 during reset, and no write commits.
- **Single ALU write.** Issue rd = 3, then alu_req with rd = 3 and data = 8'hA5. Required:
  - alu_ack = 1 in cycle N.
  - wb_we = 1, wb_rd = 3, wb_data = 8'hA5 in cycle N+1.
  - pending[3] = 1 from issue through N+1, and 0 in N+2.
  - hz_r1 = 1 for chk_r1 = 3 until pending[3] clears.
- **Contention.** Hold alu_req and mem_req continuously with distinct rd values. Required:
  - The first ack goes to the ALU, then grants alternate every cycle.
  - wb_we stays 1 every cycle, and no request waits more than 1 cycle.
- **rd = 0 discard.** Send mem_req with rd = 0 and data = 8'hFF. Required: mem_ack = 1, wb_we = 0 in the next cycle, pending unchanged, and hz_r1 = 0 for chk_r1 = 0.
- **Set/clear collision.** Make a write to rd = 5 commit (wb_we = 1, wb_rd = 5) on the same edge as issue_valid with issue_rd = 5. Required: pending[5] = 1 after that edge.
